ibex_wb_buffer: RTL and testbench
=================================

IBEX_WB_BUFFER -- requirements
Module: ibex_wb_buffer

Interface
REQ-001 Parameter Depth, default 2: number of EX result entries held (legal values 2 or 4).
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 ex_valid_i  input  1  EX result valid (driven from EX ex_valid_o qualified by instruction valid).
REQ-005 ex_ready_o  output  1  buffer can accept an EX result this cycle.
REQ-006 ex_result_i  input  32  EX result data.
REQ-007 ex_rd_addr_i  input  5  destination register.
REQ-008 ex_rd_we_i  input  1  instruction writes rd.
REQ-009 lsu_rdata_valid_i  input  1  load data returning this cycle.
REQ-010 lsu_rdata_i  input  32  load data.
REQ-011 lsu_rd_addr_i  input  5  load destination register.
REQ-012 rf_we_o  output  1  register-file write enable.
REQ-013 rf_waddr_o  output  5  register-file write address.
REQ-014 rf_wdata_o  output  32  register-file write data.
REQ-015 fwd_rs1_addr_i, fwd_rs2_addr_i  input  5 each  ID operand addresses for forwarding lookup.
REQ-016 fwd_rs1_hit_o, fwd_rs2_hit_o  output  1 each  pending buffered write matches the address.
REQ-017 fwd_rs1_data_o, fwd_rs2_data_o  output  32 each  forwarded data; 0 when no hit.
REQ-018 wb_retire_o  output  1  one-cycle pulse per EX entry drained.
REQ-019 empty_o  output  1  no EX entries held.

Function
REQ-020 Push occurs when ex_valid_i and ex_ready_o are both 1; the entry {result, rd, we} is appended at the tail.
REQ-021 ex_ready_o = (count < Depth), combinational from registered count; a full buffer never accepts, even if a pop occurs in the same cycle.
REQ-022 LSU write has priority: when lsu_rdata_valid_i=1, rf_we_o=(lsu_rd_addr_i!=0), rf_waddr_o=lsu_rd_addr_i, rf_wdata_o=lsu_rdata_i in the same cycle, and no pop occurs.
REQ-023 Otherwise, when count>0, the head pops: rf_we_o=(head.we && head.rd!=0), address/data from head, wb_retire_o=1.
REQ-024 An entry pushed into an empty buffer is written back no earlier than the following cycle (latency 1, no input-to-rf bypass).
REQ-025 When neither LSU write nor pop occurs, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, wb_retire_o=0.
REQ-026 Simultaneous push and pop: count unchanged, pointers both advance, wrap modulo Depth.
REQ-027 Forwarding: hit when any held entry has we=1, rd!=0, rd equal to the queried address; with multiple matches the youngest entry supplies data.
REQ-028 The head entry being popped this cycle still participates in forwarding; the entry being pushed this cycle does not; LSU data is never forwarded.
REQ-029 Address 0 never hits and is never written to the register file.
REQ-030 empty_o = (count == 0).

Reset
REQ-031 While rst_i=1 at a clock edge: count, head and tail pointers cleared to 0; entry valid state discarded.
REQ-032 Output values in reset state: ex_ready_o=1, empty_o=1, rf_we_o=0 (unless lsu_rdata_valid_i), wb_retire_o=0, fwd hits 0, fwd data 0.
REQ-033 Reset asserted mid-operation drops all pending entries; no write of dropped entries occurs afterwards.

Structure
REQ-034 ibex_pkg holds WbBufDepthDefault=2 and typedef wb_entry_t {logic [31:0] data; logic [4:0] rd; logic we}.
REQ-035 One sub-module, ibex_wb_fwd_lookup: combinational youngest-match search over the entry array, instantiated once per read port.
REQ-036 Entry storage is flop-based; no memory macro.

Verification
REQ-037 Push {0xDEADBEEF, rd=5, we=1} into empty buffer -> cycle+1: rf_we_o=1, waddr 5, wdata 0xDEADBEEF, wb_retire_o=1, empty_o=1 after.
REQ-038 Push 2 entries (Depth=2) with lsu_rdata_valid_i held 1 -> ex_ready_o=0, third ex_valid_i not accepted; LSU writes each cycle; after LSU drops, entries drain in order over 2 cycles.
REQ-039 Entries {rd=7, 0x1}, {rd=7, 0x2} held, fwd_rs1_addr_i=7 -> fwd_rs1_hit_o=1, fwd_rs1_data_o=0x2; fwd_rs2_addr_i=0 -> hit 0, data 0.
REQ-040 Push {rd=0, we=1} -> pop cycle: rf_we_o=0, wb_retire_o=1.
REQ-041 Continuous push every cycle with no LSU traffic for 10 cycles -> 10 writes in order, count stays 1, pointers wrap correctly.
REQ-042 Assert rst_i with 2 entries held -> next cycle empty_o=1, ex_ready_o=1, no rf write of dropped entries.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared types and sizes for the writeback buffer slice.
package ibex_pkg;

  localparam int unsigned WbBufDepthDefault = 2;
  localparam int unsigned RegAddrW          = 5;
  localparam int unsigned DataW             = 32;

  typedef struct packed {
    logic [DataW-1:0]    data;
    logic [RegAddrW-1:0] rd;
    logic                we;
  } wb_entry_t;

  // An entry can supply forwarded data only for a real, non-x0 write to addr.
  function automatic logic fwd_match(wb_entry_t e, logic [RegAddrW-1:0] addr);
    return e.we && (e.rd != '0) && (e.rd == addr);
  endfunction

endpackage

// File: rtl/ibex_wb_buffer_if.sv
// EX/LSU-to-writeback handshake and register-file write port bundle.
interface ibex_wb_buffer_if;
  import ibex_pkg::*;

  logic                ex_valid_i;
  logic                ex_ready_o;
  logic [DataW-1:0]    ex_result_i;
  logic [RegAddrW-1:0] ex_rd_addr_i;
  logic                ex_rd_we_i;
  logic                lsu_rdata_valid_i;
  logic [DataW-1:0]    lsu_rdata_i;
  logic [RegAddrW-1:0] lsu_rd_addr_i;
  logic                rf_we_o;
  logic [RegAddrW-1:0] rf_waddr_o;
  logic [DataW-1:0]    rf_wdata_o;
  logic                wb_retire_o;
  logic                empty_o;

  modport slave (
    input  ex_valid_i, ex_result_i, ex_rd_addr_i, ex_rd_we_i,
           lsu_rdata_valid_i, lsu_rdata_i, lsu_rd_addr_i,
    output ex_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, wb_retire_o, empty_o
  );

  modport master (
    output ex_valid_i, ex_result_i, ex_rd_addr_i, ex_rd_we_i,
           lsu_rdata_valid_i, lsu_rdata_i, lsu_rd_addr_i,
    input  ex_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, wb_retire_o, empty_o
  );

endinterface

// File: rtl/ibex_wb_fwd_lookup.sv
// Youngest-match forwarding search over the held entries of the writeback buffer.
module ibex_wb_fwd_lookup
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = WbBufDepthDefault
) (
  input  wb_entry_t [Depth-1:0]        i_entries,
  input  logic [$clog2(Depth)-1:0]     i_head,
  input  logic [$clog2(Depth+1)-1:0]   i_count,
  input  logic [RegAddrW-1:0]          i_addr,
  output logic                         o_hit,
  output logic [DataW-1:0]             o_data
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [PtrW-1:0] w_idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      w_idx = PtrW'(i_head + PtrW'(i));
      if ((CntW'(i) < i_count) && fwd_match(i_entries[w_idx], i_addr)) begin
        o_hit  = 1'b1;
        o_data = i_entries[w_idx].data;
      end
    end
  end

endmodule

// File: rtl/ibex_wb_buffer.sv
// Small FIFO of EX results draining into the register file; LSU load data takes the port first.
module ibex_wb_buffer
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = WbBufDepthDefault
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ibex_wb_buffer_if.slave     bus,
  input  logic [RegAddrW-1:0] fwd_rs1_addr_i,
  input  logic [RegAddrW-1:0] fwd_rs2_addr_i,
  output logic                fwd_rs1_hit_o,
  output logic [DataW-1:0]    fwd_rs1_data_o,
  output logic                fwd_rs2_hit_o,
  output logic [DataW-1:0]    fwd_rs2_data_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  wb_entry_t [Depth-1:0] r_entries;
  logic [PtrW-1:0]       r_head;
  logic [PtrW-1:0]       r_tail;
  logic [CntW-1:0]       r_count;

  logic      w_push;
  logic      w_pop;
  wb_entry_t w_head;
  wb_entry_t w_new;

  assign w_head = r_entries[r_head];
  assign w_new  = '{data: bus.ex_result_i, rd: bus.ex_rd_addr_i, we: bus.ex_rd_we_i};

  assign bus.ex_ready_o  = (r_count < CntW'(Depth));
  assign bus.empty_o     = (r_count == '0);
  assign w_push          = bus.ex_valid_i && bus.ex_ready_o;
  // A reset cycle never drains, so entries being dropped are never written.
  assign w_pop           = !bus.lsu_rdata_valid_i && (r_count != '0) && !rst_i;
  assign bus.wb_retire_o = w_pop;

  always_comb begin
    bus.rf_we_o    = 1'b0;
    bus.rf_waddr_o = '0;
    bus.rf_wdata_o = '0;
    if (bus.lsu_rdata_valid_i) begin
      bus.rf_we_o    = (bus.lsu_rd_addr_i != '0);
      bus.rf_waddr_o = bus.lsu_rd_addr_i;
      bus.rf_wdata_o = bus.lsu_rdata_i;
    end else if (w_pop) begin
      bus.rf_we_o    = w_head.we && (w_head.rd != '0);
      bus.rf_waddr_o = w_head.rd;
      bus.rf_wdata_o = w_head.data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PtrW'(1);
      if (w_pop)  r_head <= r_head + PtrW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CntW'(1);
    end
  end

  // Payload flops need no reset; validity is carried entirely by r_count.
  always_ff @(posedge clk_i) begin
    if (w_push) r_entries[r_tail] <= w_new;
  end

  ibex_wb_fwd_lookup #(.Depth(Depth)) u_fwd_rs1 (
    .i_entries (r_entries),
    .i_head    (r_head),
    .i_count   (r_count),
    .i_addr    (fwd_rs1_addr_i),
    .o_hit     (fwd_rs1_hit_o),
    .o_data    (fwd_rs1_data_o)
  );

  ibex_wb_fwd_lookup #(.Depth(Depth)) u_fwd_rs2 (
    .i_entries (r_entries),
    .i_head    (r_head),
    .i_count   (r_count),
    .i_addr    (fwd_rs2_addr_i),
    .o_hit     (fwd_rs2_hit_o),
    .o_data    (fwd_rs2_data_o)
  );

endmodule

// File: tb/tb_ibex_wb_buffer.sv
// Scoreboard bench for ibex_wb_buffer: queue-based reference model, per-cycle expected outputs.
module tb_ibex_wb_buffer;
  import ibex_pkg::*;

  localparam int unsigned DEPTH = 2;

  typedef struct {
    logic        rdy;
    logic        emp;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ret;
    logic        h1;
    logic [31:0] d1;
    logic        h2;
    logic [31:0] d2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2;
  logic        h1, h2;
  logic [31:0] d1, d2;

  ibex_wb_buffer_if bus ();

  ibex_wb_buffer #(.Depth(DEPTH)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus),
    .fwd_rs1_addr_i (rs1),
    .fwd_rs2_addr_i (rs2),
    .fwd_rs1_hit_o  (h1),
    .fwd_rs1_data_o (d1),
    .fwd_rs2_hit_o  (h2),
    .fwd_rs2_data_o (d2)
  );

  always #5 clk = ~clk;

  wb_entry_t model_q[$];
  exp_t      exp_q[$];
  int        n_cmp = 0;
  int        n_err = 0;
  bit        armed = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Youngest held entry writing a non-zero register equal to a.
  function automatic void model_fwd(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = 32'h0;
    for (int i = model_q.size() - 1; i >= 0; i--) begin
      if (model_q[i].we && model_q[i].rd == a && a != 5'd0) begin
        h = 1'b1;
        d = model_q[i].data;
        break;
      end
    end
  endfunction

  task automatic drive(input logic r, input logic v, input logic [31:0] d, input logic [4:0] rd,
                       input logic we, input logic lv, input logic [31:0] ld, input logic [4:0] la,
                       input logic [4:0] a1, input logic [4:0] a2);
    exp_t      e;
    wb_entry_t hd;
    int        sz;
    @(posedge clk);
    #1;
    rst                   = r;
    bus.ex_valid_i        = v;
    bus.ex_result_i       = d;
    bus.ex_rd_addr_i      = rd;
    bus.ex_rd_we_i        = we;
    bus.lsu_rdata_valid_i = lv;
    bus.lsu_rdata_i       = ld;
    bus.lsu_rd_addr_i     = la;
    rs1                   = a1;
    rs2                   = a2;
    sz    = model_q.size();
    e     = '{default: '0};
    e.rdy = (sz < int'(DEPTH));
    e.emp = (sz == 0);
    model_fwd(a1, e.h1, e.d1);
    model_fwd(a2, e.h2, e.d2);
    if (lv) begin
      e.we = (la != 5'd0);
      e.wa = la;
      e.wd = ld;
    end else if (!r && sz > 0) begin
      hd    = model_q.pop_front();
      e.we  = hd.we && (hd.rd != 5'd0);
      e.wa  = hd.rd;
      e.wd  = hd.data;
      e.ret = 1'b1;
    end
    if (v && sz < int'(DEPTH)) model_q.push_back('{data: d, rd: rd, we: we});
    if (r) model_q.delete();
    exp_q.push_back(e);
    armed = 1'b1;
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    drive(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, a1, a2);
  endtask

  // Monitor: every cycle the DUT presents its outputs and they are matched against the next expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (armed) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_underflow: got no expectation expected one queued (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("ex_ready", 32'(bus.ex_ready_o), 32'(e.rdy));
          chk("empty", 32'(bus.empty_o), 32'(e.emp));
          chk("rf_we", 32'(bus.rf_we_o), 32'(e.we));
          chk("rf_waddr", 32'(bus.rf_waddr_o), 32'(e.wa));
          chk("rf_wdata", bus.rf_wdata_o, e.wd);
          chk("wb_retire", 32'(bus.wb_retire_o), 32'(e.ret));
          chk("fwd_rs1_hit", 32'(h1), 32'(e.h1));
          chk("fwd_rs1_data", d1, e.d1);
          chk("fwd_rs2_hit", 32'(h2), 32'(e.h2));
          chk("fwd_rs2_data", d2, e.d2);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.ex_valid_i = 1'b0; bus.ex_result_i = '0; bus.ex_rd_addr_i = '0; bus.ex_rd_we_i = 1'b0;
    bus.lsu_rdata_valid_i = 1'b0; bus.lsu_rdata_i = '0; bus.lsu_rd_addr_i = '0;
    rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);

    // Reset state, then a single push drained one cycle later.
    idle(5'd5, 5'd0);
    drive(1'b0, 1'b1, 32'hDEADBEEF, 5'd5, 1'b1, 1'b0, 32'h0, 5'd0, 5'd5, 5'd0);
    idle(5'd5, 5'd0);
    idle(5'd5, 5'd0);

    // Held LSU traffic fills the buffer; third push refused; then in-order drain.
    drive(1'b0, 1'b1, 32'h1111_0001, 5'd1, 1'b1, 1'b1, 32'hA0A0_0001, 5'd9, 5'd1, 5'd2);
    drive(1'b0, 1'b1, 32'h2222_0002, 5'd2, 1'b1, 1'b1, 32'hA0A0_0002, 5'd10, 5'd1, 5'd2);
    drive(1'b0, 1'b1, 32'h3333_0003, 5'd3, 1'b1, 1'b1, 32'hA0A0_0003, 5'd0, 5'd3, 5'd2);
    idle(5'd1, 5'd2);
    idle(5'd1, 5'd2);
    idle(5'd3, 5'd0);

    // Two writes to x7 held: youngest forwards; x0 never hits.
    drive(1'b0, 1'b1, 32'h1, 5'd7, 1'b1, 1'b1, 32'hB0, 5'd4, 5'd7, 5'd0);
    drive(1'b0, 1'b1, 32'h2, 5'd7, 1'b1, 1'b1, 32'hB1, 5'd4, 5'd7, 5'd0);
    drive(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 32'hB2, 5'd4, 5'd7, 5'd0);
    idle(5'd7, 5'd0);
    idle(5'd7, 5'd0);

    // x0 destination retires without a register-file write.
    drive(1'b0, 1'b1, 32'hCAFE, 5'd0, 1'b1, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Back-to-back pushes: count holds at one, pointers wrap.
    for (int i = 0; i < 10; i++)
      drive(1'b0, 1'b1, 32'h5000 + 32'(i), 5'(i + 1), 1'b1, 1'b0, 32'h0, 5'd0, 5'(i), 5'(i + 1));
    idle(5'd10, 5'd0);

    // Reset with two entries held drops both.
    drive(1'b0, 1'b1, 32'h7777, 5'd12, 1'b1, 1'b1, 32'hC0, 5'd3, 5'd12, 5'd13);
    drive(1'b0, 1'b1, 32'h8888, 5'd13, 1'b1, 1'b1, 32'hC1, 5'd3, 5'd12, 5'd13);
    drive(1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd12, 5'd13);
    idle(5'd12, 5'd13);
    idle(5'd12, 5'd13);

    // Random traffic with small register addresses to provoke forwarding collisions.
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0), $urandom,
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) == 0), $urandom, 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    idle(5'd0, 5'd0);

    @(negedge clk);
    #1;
    armed = 1'b0;
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
